axis_md_broadcaster: RTL and testbench
======================================

AXIS_MD_BROADCASTER -- requirements
Module: axis_md_broadcaster

Interface
REQ-001 SHALL have parameter DW, default 512, giving the data width in bits (multiple of 8).
REQ-002 SHALL have parameter NUM_OUT, default 2, giving the number of output streams (legal range 1..8).
REQ-003 SHALL have parameter CNT_W, default 32, giving the packet counter width.
REQ-004 clk  input  1  the single clock; all logic is rising-edge.
REQ-005 resetn  input  1  reset, asynchronous and active-low.
REQ-006 AXIS_IN_TDATA / AXIS_IN_TKEEP / AXIS_IN_TLAST / AXIS_IN_TVALID  input  DW / DW/8 / 1 / 1  input stream.
REQ-007 AXIS_IN_TREADY  output  1  input ready.
REQ-008 OUT_MASK  input  NUM_OUT  per-output enable, sampled at start of packet.
REQ-009 AXIS_OUT_TDATA  output  NUM_OUT*DW  per-output data; output i occupies bits [i*DW +: DW].
REQ-010 AXIS_OUT_TKEEP / AXIS_OUT_TLAST  output  NUM_OUT*DW/8 / NUM_OUT  per-output keep and last, packed as in REQ-009.
REQ-011 AXIS_OUT_TVALID / AXIS_OUT_TREADY  output / input  NUM_OUT each  per-output handshake.
REQ-012 PKT_CNT  output  CNT_W  count of accepted TLAST beats.

Function
REQ-013 SHALL hold one beat in a single shared register (data, keep, last) plus a NUM_OUT-bit pending vector.
REQ-014 AXIS_OUT_TVALID[i] SHALL equal pending[i], registered with no combinational path from any input.
REQ-015 All outputs SHALL present the same registered TDATA/TKEEP/TLAST.
REQ-016 Output i SHALL complete when TVALID[i] && TREADY[i]; pending[i] clears on the next edge. Outputs complete independently, in any order and on any cycles.
REQ-017 AXIS_IN_TREADY SHALL be 1 when (pending & ~AXIS_OUT_TREADY) == 0, i.e. when the register is empty or is fully draining this cycle.
REQ-018 On input acceptance (TVALID && TREADY), the following SHALL happen on the same edge:
- register loads TDATA, TKEEP and TLAST;
- pending loads the active packet mask (pkt_mask).
REQ-019 Latency SHALL be 1 cycle from input acceptance to TVALID; sustained throughput SHALL be 1 beat/cycle when all enabled outputs hold TREADY=1.
REQ-020 State sop SHALL reset to 1 and, on each accepted beat, load AXIS_IN_TLAST.
REQ-021 When sop=1 the active mask SHALL be OUT_MASK (combinational) and pkt_mask SHALL load OUT_MASK on acceptance; when sop=0 the active mask SHALL be the held pkt_mask. OUT_MASK changes mid-packet SHALL have no effect until the next packet.
REQ-022 A beat accepted with active mask == 0 SHALL be consumed and discarded: pending stays 0, no output asserts TVALID, and sop/PKT_CNT update normally.
REQ-023 A disabled output SHALL never assert TVALID; its TREADY SHALL be ignored.
REQ-024 PKT_CNT SHALL increment by 1 on each accepted beat with TLAST=1, masked or not, and SHALL wrap from 2^CNT_W-1 to 0.
REQ-025 Simultaneous drain and accept SHALL overwrite the register with no bubble cycle and no duplicate or lost beat.
REQ-026 While any pending bit remains set after the current cycle, TDATA/TKEEP/TLAST SHALL remain stable.

Reset
REQ-027 Asserting resetn=0 SHALL asynchronously force:
- pending = 0, hence all AXIS_OUT_TVALID = 0;
- AXIS_OUT_TDATA/TKEEP/TLAST = 0;
- sop = 1, pkt_mask = 0, PKT_CNT = 0.
REQ-028 Reset mid-packet SHALL drop the held beat and partial packet; the first accepted beat after release SHALL start a new packet.
REQ-029 AXIS_IN_TREADY SHALL be 1 during and immediately after reset (pending = 0).

Verification
REQ-030 NUM_OUT=2, mask=11, both TREADY=1, 8-beat packet streamed back-to-back -> both outputs receive 8 identical beats at 1 beat/cycle, first TVALID 1 cycle after the first acceptance, PKT_CNT=1.
REQ-031 mask=11, TREADY[0]=1, TREADY[1]=0 for 3 cycles then 1 -> beat 0 completes on out0 at once; AXIS_IN_TREADY=0 for 3 cycles; out1 gets the same beat; no duplicate on out0.
REQ-032 Packet starts with mask=01, OUT_MASK changed to 10 after beat 1 of 4 -> all 4 beats appear only on out0; the next packet goes only to out1.
REQ-033 mask=00, 3-beat packet -> no TVALID on any output, AXIS_IN_TREADY=1 throughout, PKT_CNT increments by 1.
REQ-034 CNT_W=4, 17 single-beat packets -> PKT_CNT reads 1 after the wrap.
REQ-035 resetn pulsed low while out1 is pending mid-packet -> all TVALID=0 immediately (asynchronous); after release a new 2-beat packet is delivered with the new OUT_MASK.

Source files
------------

// File: rtl/axis_md_broadcaster_if.sv
// Bus bundle for the multi-destination AXI-Stream broadcaster: one input
// stream, NUM_OUT packed output streams, the per-packet output mask and
// the packet counter.
interface axis_md_broadcaster_if #(
   parameter int DW      = 512,
   parameter int NUM_OUT = 2,
   parameter int CNT_W   = 32
);
   logic [DW-1:0]             AXIS_IN_TDATA;
   logic [DW/8-1:0]           AXIS_IN_TKEEP;
   logic                      AXIS_IN_TLAST;
   logic                      AXIS_IN_TVALID;
   logic                      AXIS_IN_TREADY;
   logic [NUM_OUT-1:0]        OUT_MASK;
   logic [NUM_OUT*DW-1:0]     AXIS_OUT_TDATA;
   logic [NUM_OUT*DW/8-1:0]   AXIS_OUT_TKEEP;
   logic [NUM_OUT-1:0]        AXIS_OUT_TLAST;
   logic [NUM_OUT-1:0]        AXIS_OUT_TVALID;
   logic [NUM_OUT-1:0]        AXIS_OUT_TREADY;
   logic [CNT_W-1:0]          PKT_CNT;

   // Traffic source / sink side (drives the input stream and output readies)
   modport master (
      output AXIS_IN_TDATA, AXIS_IN_TKEEP, AXIS_IN_TLAST, AXIS_IN_TVALID,
      input  AXIS_IN_TREADY,
      output OUT_MASK,
      input  AXIS_OUT_TDATA, AXIS_OUT_TKEEP, AXIS_OUT_TLAST, AXIS_OUT_TVALID,
      output AXIS_OUT_TREADY,
      input  PKT_CNT
   );

   // Broadcaster side
   modport slave (
      input  AXIS_IN_TDATA, AXIS_IN_TKEEP, AXIS_IN_TLAST, AXIS_IN_TVALID,
      output AXIS_IN_TREADY,
      input  OUT_MASK,
      output AXIS_OUT_TDATA, AXIS_OUT_TKEEP, AXIS_OUT_TLAST, AXIS_OUT_TVALID,
      input  AXIS_OUT_TREADY,
      output PKT_CNT
   );
endinterface

// File: rtl/axis_md_broadcaster.sv
// Multi-destination AXI-Stream broadcaster. A single shared beat register
// feeds every output; a pending vector tracks which enabled outputs still
// owe a handshake for the held beat. The output mask is latched at start of
// packet so mask changes only take effect on packet boundaries.
module axis_md_broadcaster #(
   parameter int DW      = 512,
   parameter int NUM_OUT = 2,
   parameter int CNT_W   = 32
) (
   input  logic                 clk,
   input  logic                 resetn,
   axis_md_broadcaster_if.slave bus
);
   localparam int KW = DW / 8;

   logic [DW-1:0]      data_reg;
   logic [KW-1:0]      keep_reg;
   logic               last_reg;
   logic [NUM_OUT-1:0] pending_reg;
   logic [NUM_OUT-1:0] pending_next;
   logic [NUM_OUT-1:0] pkt_mask_reg;
   logic [NUM_OUT-1:0] active_mask;
   logic [NUM_OUT-1:0] stalled;
   logic               sop_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic               in_ready;
   logic               accept;

   // Handshake bookkeeping: input is ready once no pending output is stalled,
   // so a full drain and a fresh load can share one edge.
   always_comb begin
      stalled      = pending_reg & ~bus.AXIS_OUT_TREADY;
      in_ready     = (stalled == '0);
      accept       = bus.AXIS_IN_TVALID & in_ready;
      active_mask  = sop_reg ? bus.OUT_MASK : pkt_mask_reg;
      pending_next = accept ? active_mask : stalled;
   end

   // Shared beat register, reloaded on every accepted beat
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         data_reg <= '0;
         keep_reg <= '0;
         last_reg <= 1'b0;
      end else if (accept) begin
         data_reg <= bus.AXIS_IN_TDATA;
         keep_reg <= bus.AXIS_IN_TKEEP;
         last_reg <= bus.AXIS_IN_TLAST;
      end
   end

   // Per-output pending bits: cleared on completion, reloaded from the mask
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pending_reg <= '0;
      end else begin
         pending_reg <= pending_next;
      end
   end

   // Packet framing: track start of packet and latch the mask for its duration
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sop_reg      <= 1'b1;
         pkt_mask_reg <= '0;
      end else if (accept) begin
         sop_reg <= bus.AXIS_IN_TLAST;
         if (sop_reg) begin
            pkt_mask_reg <= bus.OUT_MASK;
         end
      end
   end

   // Packet counter: one count per accepted last beat, including masked packets
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_reg <= '0;
      end else if (accept && bus.AXIS_IN_TLAST) begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   assign bus.AXIS_IN_TREADY  = in_ready;
   assign bus.AXIS_OUT_TVALID = pending_reg;
   assign bus.PKT_CNT         = cnt_reg;

   // Every output lane carries the same registered beat
   generate
      for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_lane
         assign bus.AXIS_OUT_TDATA[gi*DW +: DW] = data_reg;
         assign bus.AXIS_OUT_TKEEP[gi*KW +: KW] = keep_reg;
         assign bus.AXIS_OUT_TLAST[gi]          = last_reg;
      end
   endgenerate
endmodule

// File: tb/tb_axis_md_broadcaster.sv
// Bench for axis_md_broadcaster: per-output expected-beat queues model the
// broadcast, checked every cycle, plus literal checks for directed scenarios.
module tb_axis_md_broadcaster;
   localparam int DW = 32;
   localparam int KW = DW / 8;
   localparam int NO = 2;
   localparam int CW = 4;

   typedef struct {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
   } beat_t;

   logic clk;
   logic resetn;
   axis_md_broadcaster_if #(.DW(DW), .NUM_OUT(NO), .CNT_W(CW)) bus ();

   axis_md_broadcaster #(.DW(DW), .NUM_OUT(NO), .CNT_W(CW)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   int            n_cmp = 0;
   int            n_bad = 0;
   int            recv[NO];
   beat_t         q_exp[NO][$];
   logic          m_sop = 1'b1;
   logic [NO-1:0] m_mask = '0;
   logic [CW-1:0] m_cnt = '0;
   bit            rand_rdy = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference model: each accepted beat is queued for every output enabled
   // for its packet; a queued beat must be visible until that output takes it.
   always @(negedge clk) begin : cmp_blk
      logic          exp_rdy;
      logic [NO-1:0] act;
      beat_t         b;
      if (!resetn) begin
         for (int i = 0; i < NO; i++) q_exp[i].delete();
         m_sop  = 1'b1;
         m_mask = '0;
         m_cnt  = '0;
         chk("rst_tvalid", bus.AXIS_OUT_TVALID, 0);
         chk("rst_in_tready", bus.AXIS_IN_TREADY, 1);
         chk("rst_pkt_cnt", bus.PKT_CNT, 0);
         chk("rst_tdata", bus.AXIS_OUT_TDATA, 0);
      end else begin
         exp_rdy = 1'b1;
         for (int i = 0; i < NO; i++) begin
            chk($sformatf("tvalid%0d", i), bus.AXIS_OUT_TVALID[i], q_exp[i].size() != 0);
            if (q_exp[i].size() != 0) begin
               b = q_exp[i][0];
               chk($sformatf("tdata%0d", i), bus.AXIS_OUT_TDATA[i*DW +: DW], b.data);
               chk($sformatf("tkeep%0d", i), bus.AXIS_OUT_TKEEP[i*KW +: KW], b.keep);
               chk($sformatf("tlast%0d", i), bus.AXIS_OUT_TLAST[i], b.last);
               if (!bus.AXIS_OUT_TREADY[i]) exp_rdy = 1'b0;
            end
         end
         chk("in_tready", bus.AXIS_IN_TREADY, exp_rdy);
         chk("pkt_cnt", bus.PKT_CNT, m_cnt);
         for (int i = 0; i < NO; i++) begin
            if (q_exp[i].size() != 0 && bus.AXIS_OUT_TREADY[i]) begin
               void'(q_exp[i].pop_front());
               recv[i]++;
            end
         end
         if (bus.AXIS_IN_TVALID && exp_rdy) begin
            act = m_sop ? bus.OUT_MASK : m_mask;
            if (m_sop) m_mask = bus.OUT_MASK;
            for (int i = 0; i < NO; i++) begin
               if (act[i]) q_exp[i].push_back('{bus.AXIS_IN_TDATA, bus.AXIS_IN_TKEEP, bus.AXIS_IN_TLAST});
            end
            if (bus.AXIS_IN_TLAST) m_cnt = m_cnt + 1'b1;
            m_sop = bus.AXIS_IN_TLAST;
         end
      end
   end

   // Random backpressure on every output while enabled
   always @(posedge clk) begin
      if (rand_rdy) begin
         #1;
         for (int i = 0; i < NO; i++) bus.AXIS_OUT_TREADY[i] = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present one beat and hold it until accepted; returns cycles spent.
   task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                            input logic l, output int cycles);
      bit done = 1'b0;
      cycles = 0;
      bus.AXIS_IN_TDATA  = d;
      bus.AXIS_IN_TKEEP  = k;
      bus.AXIS_IN_TLAST  = l;
      bus.AXIS_IN_TVALID = 1'b1;
      while (!done) begin
         @(negedge clk);
         done = bus.AXIS_IN_TREADY && resetn;
         @(posedge clk);
         #1;
         cycles++;
         if (!done && cycles > 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: beat %0h not accepted within 200 cycles", d);
            done = 1'b1;
         end
      end
      bus.AXIS_IN_TVALID = 1'b0;
   endtask

   initial begin
      int cyc;
      int tot;
      int r0;
      int r1;
      for (int i = 0; i < NO; i++) recv[i] = 0;
      resetn              = 1'b0;
      bus.AXIS_IN_TDATA   = '0;
      bus.AXIS_IN_TKEEP   = '0;
      bus.AXIS_IN_TLAST   = 1'b0;
      bus.AXIS_IN_TVALID  = 1'b0;
      bus.OUT_MASK        = '0;
      bus.AXIS_OUT_TREADY = '0;
      step(3);
      resetn = 1'b1;
      step(1);

      // 8-beat packet, both outputs, full rate
      bus.OUT_MASK = 2'b11;
      bus.AXIS_OUT_TREADY = 2'b11;
      r0 = recv[0]; r1 = recv[1]; tot = 0;
      chk("r030_idle_tvalid", bus.AXIS_OUT_TVALID, 0);
      for (int b = 0; b < 8; b++) begin
         send_beat(DW'($urandom), '1, b == 7, cyc);
         tot += cyc;
         if (b == 0) chk("r030_latency_tvalid", bus.AXIS_OUT_TVALID, 2'b11);
      end
      chk("r030_cycles", tot, 8);
      chk("r030_pkt_cnt", bus.PKT_CNT, 1);
      step(3);
      chk("r030_out0_beats", recv[0] - r0, 8);
      chk("r030_out1_beats", recv[1] - r1, 8);
      $display("txn r030: 8-beat broadcast done");

      // out1 stalls 3 cycles while out0 completes at once
      bus.AXIS_OUT_TREADY = 2'b01;
      r0 = recv[0]; r1 = recv[1];
      send_beat(32'hA5A5_0031, 4'hF, 1'b1, cyc);
      repeat (3) begin
         @(negedge clk);
         chk("r031_stall_in_tready", bus.AXIS_IN_TREADY, 0);
         @(posedge clk);
         #1;
      end
      bus.AXIS_OUT_TREADY = 2'b11;
      @(negedge clk);
      chk("r031_release_in_tready", bus.AXIS_IN_TREADY, 1);
      step(2);
      chk("r031_out0_beats", recv[0] - r0, 1);
      chk("r031_out1_beats", recv[1] - r1, 1);
      chk("r031_pkt_cnt", bus.PKT_CNT, 2);
      $display("txn r031: stalled out1 delivered once");

      // mask changed mid-packet only affects the following packet
      bus.OUT_MASK = 2'b01;
      r0 = recv[0]; r1 = recv[1];
      for (int b = 0; b < 4; b++) begin
         send_beat(DW'(32'h3200 + b), 4'h3, b == 3, cyc);
         if (b == 1) bus.OUT_MASK = 2'b10;
      end
      step(2);
      chk("r032_p1_out0", recv[0] - r0, 4);
      chk("r032_p1_out1", recv[1] - r1, 0);
      r0 = recv[0]; r1 = recv[1];
      send_beat(32'h3210, 4'h1, 1'b0, cyc);
      send_beat(32'h3211, 4'h7, 1'b1, cyc);
      step(2);
      chk("r032_p2_out0", recv[0] - r0, 0);
      chk("r032_p2_out1", recv[1] - r1, 2);
      chk("r032_pkt_cnt", bus.PKT_CNT, 4);
      $display("txn r032: mask latched per packet");

      // fully masked packet is consumed silently
      bus.OUT_MASK = 2'b00;
      bus.AXIS_OUT_TREADY = 2'b00;
      r0 = recv[0]; r1 = recv[1]; tot = 0;
      for (int b = 0; b < 3; b++) begin
         send_beat(DW'($urandom), 4'hF, b == 2, cyc);
         tot += cyc;
         chk("r033_tvalid", bus.AXIS_OUT_TVALID, 0);
      end
      chk("r033_cycles", tot, 3);
      chk("r033_pkt_cnt", bus.PKT_CNT, 5);
      chk("r033_beats", (recv[0] - r0) + (recv[1] - r1), 0);
      $display("txn r033: masked packet dropped");

      // asynchronous reset while out1 holds a mid-packet beat
      bus.OUT_MASK = 2'b11;
      bus.AXIS_OUT_TREADY = 2'b01;
      send_beat(32'hDEAD_0035, 4'hF, 1'b0, cyc);
      #2;
      resetn = 1'b0;
      #1;
      chk("r035_async_tvalid", bus.AXIS_OUT_TVALID, 0);
      chk("r035_async_tdata", bus.AXIS_OUT_TDATA, 0);
      chk("r035_async_pkt_cnt", bus.PKT_CNT, 0);
      chk("r035_async_in_tready", bus.AXIS_IN_TREADY, 1);
      step(1);
      resetn = 1'b1;
      bus.OUT_MASK = 2'b10;
      bus.AXIS_OUT_TREADY = 2'b11;
      r0 = recv[0]; r1 = recv[1];
      send_beat(32'h3500, 4'hF, 1'b0, cyc);
      send_beat(32'h3501, 4'hF, 1'b1, cyc);
      step(2);
      chk("r035_out0_beats", recv[0] - r0, 0);
      chk("r035_out1_beats", recv[1] - r1, 2);
      chk("r035_pkt_cnt", bus.PKT_CNT, 1);
      $display("txn r035: reset mid-packet recovered");

      // 17 single-beat packets on a 4-bit counter: 1 + 17 = 18 wraps to 2
      for (int p = 0; p < 17; p++) begin
         bus.OUT_MASK = NO'($urandom);
         send_beat(DW'($urandom), 4'hF, 1'b1, cyc);
      end
      chk("r034_pkt_cnt_wrap", bus.PKT_CNT, 2);
      step(2);
      $display("txn r034: counter wrapped");

      // random traffic, random masks, random backpressure
      rand_rdy = 1'b1;
      for (int b = 0; b < 400; b++) begin
         bus.OUT_MASK = NO'($urandom);
         if ($urandom_range(0, 4) == 0) step(1);
         send_beat(DW'($urandom), KW'($urandom), $urandom_range(0, 3) == 0, cyc);
      end
      rand_rdy = 1'b0;
      step(1);
      bus.AXIS_OUT_TREADY = 2'b11;
      step(3);
      chk("rand_drained", bus.AXIS_OUT_TVALID, 0);
      $display("txn random: 400 beats issued");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
